// File: rtl/memory_bus_controller.sv
// Memory bus controller: runs one fetch/load/store per request against a
// variable-latency memory with a ready handshake, with a wait-state timeout.
module memory_bus_controller #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              sel_add_bus,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] address_add_bus_out,
  input  logic [DATA_W-1:0] store_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              store_done,
  output logic              bus_error,
  output logic              stall
);

  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Counter value during the last permitted not-ready cycle.
  localparam logic [CntW-1:0] LastWait = (TIMEOUT == 0) ? '0 : CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;
  typedef enum logic [1:0] {KindFetch, KindLoad, KindStore} kind_e;

  state_e            state_q;
  kind_e             kind_q;
  logic [CntW-1:0]   wait_cnt_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_rd_q, mem_wr_q;
  logic [DATA_W-1:0] instr_q, load_q;
  logic              instr_valid_q, load_valid_q, store_done_q, bus_error_q;

  // Single FSM: latches the request, holds strobes until ready or timeout,
  // then emits one response pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      kind_q        <= KindFetch;
      wait_cnt_q    <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      instr_q       <= '0;
      load_q        <= '0;
      instr_valid_q <= 1'b0;
      load_valid_q  <= 1'b0;
      store_done_q  <= 1'b0;
      bus_error_q   <= 1'b0;
    end else begin
      instr_valid_q <= 1'b0;
      load_valid_q  <= 1'b0;
      store_done_q  <= 1'b0;
      bus_error_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            mem_addr_q  <= address_add_bus_out;
            mem_wdata_q <= store_data;
            wait_cnt_q  <= '0;
            if (!sel_add_bus) begin
              kind_q   <= KindFetch;
              mem_rd_q <= 1'b1;
            end else if (!write_en) begin
              kind_q   <= KindLoad;
              mem_rd_q <= 1'b1;
            end else begin
              kind_q   <= KindStore;
              mem_wr_q <= 1'b1;
            end
            state_q <= StAccess;
          end
        end
        StAccess: begin
          if (mem_ready) begin
            unique case (kind_q)
              KindFetch: begin
                instr_q       <= mem_rdata;
                instr_valid_q <= 1'b1;
              end
              KindLoad: begin
                load_q       <= mem_rdata;
                load_valid_q <= 1'b1;
              end
              default: store_done_q <= 1'b1;
            endcase
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            state_q  <= StResp;
          end else if ((TIMEOUT != 0) && (wait_cnt_q == LastWait)) begin
            bus_error_q <= 1'b1;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            state_q     <= StResp;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        StResp: begin
          wait_cnt_q <= '0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs straight from registers; only ready/stall decode the state.
  always_comb begin
    req_ready   = (state_q == StIdle) && !reset;
    stall       = (state_q != StIdle);
    mem_addr    = mem_addr_q;
    mem_wdata   = mem_wdata_q;
    mem_rd      = mem_rd_q;
    mem_wr      = mem_wr_q;
    instr_out   = instr_q;
    load_data   = load_q;
    instr_valid = instr_valid_q;
    load_valid  = load_valid_q;
    store_done  = store_done_q;
    bus_error   = bus_error_q;
  end

endmodule

// File: tb/tb_memory_bus_controller.sv
// Self-checking bench for memory_bus_controller with a response scoreboard.
module tb_memory_bus_controller;

  localparam int unsigned TO = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        sel_add_bus = 1'b0;
  logic        write_en = 1'b0;
  logic [15:0] address_add_bus_out = '0;
  logic [31:0] store_data = '0;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd, mem_wr, mem_ready;
  logic [31:0] mem_rdata = '0;
  logic [31:0] instr_out, load_data;
  logic        instr_valid, load_valid, store_done, bus_error, stall;

  memory_bus_controller #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk                 (clk),
    .reset               (reset),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .sel_add_bus         (sel_add_bus),
    .write_en            (write_en),
    .address_add_bus_out (address_add_bus_out),
    .store_data          (store_data),
    .mem_addr            (mem_addr),
    .mem_wdata           (mem_wdata),
    .mem_rd              (mem_rd),
    .mem_wr              (mem_wr),
    .mem_ready           (mem_ready),
    .mem_rdata           (mem_rdata),
    .instr_out           (instr_out),
    .instr_valid         (instr_valid),
    .load_data           (load_data),
    .load_valid          (load_valid),
    .store_done          (store_done),
    .bus_error           (bus_error),
    .stall               (stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  pulses;  // {instr_valid, load_valid, store_done, bus_error}
    int          kind;    // 0 fetch, 1 load, 2 store
    logic [31:0] data;
    int          rd_cycles;
    int          wr_cycles;
    int          cyc;
  } sb_entry_t;

  sb_entry_t   sb[$];
  sb_entry_t   e_mon;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          strobe_cnt = 0;
  int          wait_target = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [15:0] cur_addr = '0;
  logic [31:0] cur_wdata = '0;
  logic [31:0] model_instr = '0;
  logic [31:0] model_load = '0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: ready after wait_target not-ready strobe cycles.
  always @(posedge clk) begin
    if (reset || !(mem_rd || mem_wr)) strobe_cnt <= 0;
    else strobe_cnt <= strobe_cnt + 1;
  end
  assign mem_ready = (mem_rd || mem_wr) && (strobe_cnt == wait_target);

  // Monitor: checks strobes mid-cycle and pops the scoreboard on each pulse.
  always @(negedge clk) begin
    if (reset) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end
    if (mem_rd || mem_wr) begin
      check_value("rd_wr_excl", {63'd0, mem_rd & mem_wr}, 64'd0);
      check_value("mem_addr", {48'd0, mem_addr}, {48'd0, cur_addr});
      check_value("stall_busy", {63'd0, stall}, 64'd1);
      check_value("ready_busy", {63'd0, req_ready}, 64'd0);
      if (mem_wr) check_value("mem_wdata", {32'd0, mem_wdata}, {32'd0, cur_wdata});
      if (mem_rd) rd_cnt++;
      if (mem_wr) wr_cnt++;
    end
    if (instr_valid || load_valid || store_done || bus_error) begin
      if (sb.size() == 0) begin
        check_value("spurious_pulse", {60'd0, instr_valid, load_valid, store_done, bus_error},
                    64'd0);
      end else begin
        e_mon = sb.pop_front();
        check_value("pulse_kind", {60'd0, instr_valid, load_valid, store_done, bus_error},
                    {60'd0, e_mon.pulses});
        check_value("pulse_cyc", cyc, e_mon.cyc);
        check_value("rd_cycles", rd_cnt, e_mon.rd_cycles);
        check_value("wr_cycles", wr_cnt, e_mon.wr_cycles);
        check_value("stall_resp", {63'd0, stall}, 64'd1);
        if (e_mon.pulses == 4'b1000) model_instr = e_mon.data;
        if (e_mon.pulses == 4'b0100) model_load = e_mon.data;
        check_value("instr_out", {32'd0, instr_out}, {32'd0, model_instr});
        check_value("load_data", {32'd0, load_data}, {32'd0, model_load});
      end
      rd_cnt = 0;
      wr_cnt = 0;
    end
  end

  // kind: 0 fetch, 1 load, 2 store. wt >= TO means memory never answers.
  task automatic do_req(input int kind, input logic [15:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int wt, input bit scramble);
    sb_entry_t e;
    int        e0;
    int        n;
    bit        err;
    @(posedge clk); #1;
    check_value("ready_idle", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    sel_add_bus = (kind != 0);
    write_en = (kind == 2);
    address_add_bus_out = addr;
    store_data = wdata;
    mem_rdata = rdata;
    wait_target = wt;
    cur_addr = addr;
    cur_wdata = wdata;
    @(posedge clk); #1;
    e0 = cyc;
    req_valid = 1'b0;
    if (scramble) begin
      address_add_bus_out = 16'hFFFF;
      store_data = 32'h12345678;
      sel_add_bus = ~sel_add_bus;
      write_en = ~write_en;
    end
    err = (wt >= int'(TO));
    e.kind = kind;
    e.data = rdata;
    e.pulses = err ? 4'b0001 : (kind == 0) ? 4'b1000 : (kind == 1) ? 4'b0100 : 4'b0010;
    e.rd_cycles = (kind == 2) ? 0 : (err ? int'(TO) : wt + 1);
    e.wr_cycles = (kind == 2) ? (err ? int'(TO) : wt + 1) : 0;
    e.cyc = err ? e0 + int'(TO) : e0 + wt + 1;
    sb.push_back(e);
    n = 0;
    while (sb.size() != 0 && n < 64) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb.size() != 0) begin
      check_value("resp_timeout", 64'd0, 64'd1);
      sb.delete();
    end else begin
      check_value("ready_after", {63'd0, req_ready}, 64'd1);
      check_value("stall_after", {63'd0, stall}, 64'd0);
    end
  endtask

  initial begin
    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    check_value("rst_ready", {63'd0, req_ready}, 64'd0);
    check_value("rst_stall", {63'd0, stall}, 64'd0);
    check_value("rst_strobes", {62'd0, mem_rd, mem_wr}, 64'd0);
    check_value("rst_addr", {48'd0, mem_addr}, 64'd0);
    check_value("rst_data", {instr_out, load_data}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_value("rst_release_ready", {63'd0, req_ready}, 64'd1);

    do_req(0, 16'h0010, 32'h0, 32'hE3A01005, 0, 1'b0);   // fetch, zero wait
    do_req(1, 16'h1234, 32'h0, 32'hDEADBEEF, 3, 1'b0);   // LDR, 3 waits
    do_req(2, 16'h00FF, 32'h000000A5, 32'h55555555, 1, 1'b0);  // STR, 1 wait
    do_req(1, 16'h0200, 32'h0, 32'h77777777, 100, 1'b0); // timeout
    do_req(1, 16'h0204, 32'h0, 32'hCAFEF00D, 14, 1'b0);  // ready on last cycle
    do_req(2, 16'h0040, 32'h0BADF00D, 32'h0, 2, 1'b1);   // inputs change mid-access
    do_req(0, 16'h0044, 32'h0, 32'h13572468, 14, 1'b1);  // fetch, ready on last cycle
    for (int i = 0; i < 6; i++) begin
      do_req(int'($urandom_range(0, 2)), 16'($urandom), $urandom, $urandom,
             int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    end

    // Reset during the second wait cycle of an LDR
    do_req(1, 16'h0300, 32'h0, 32'hABCDABCD, 0, 1'b0);   // make load_data nonzero
    @(posedge clk); #1;
    req_valid = 1'b1;
    sel_add_bus = 1'b1;
    write_en = 1'b0;
    address_add_bus_out = 16'h0304;
    wait_target = 100;
    cur_addr = 16'h0304;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_value("midrst_strobes", {62'd0, mem_rd, mem_wr}, 64'd0);
    check_value("midrst_pulses", {60'd0, instr_valid, load_valid, store_done, bus_error}, 64'd0);
    check_value("midrst_data", {instr_out, load_data}, 64'd0);
    check_value("midrst_bus", {mem_addr, mem_wdata}, 64'd0);
    check_value("midrst_stall", {63'd0, stall}, 64'd0);
    check_value("midrst_ready", {63'd0, req_ready}, 64'd0);
    model_instr = '0;
    model_load = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_value("midrst_ready_after", {63'd0, req_ready}, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check_value("midrst_quiet", {60'd0, instr_valid, load_valid, store_done, bus_error}, 64'd0);

    do_req(1, 16'h0400, 32'h0, 32'h24681357, 2, 1'b0);   // works after reset
    check_value("sb_empty", sb.size(), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_bus_controller.md
Name: memory_bus_controller

Overview:
- Downstream of the address-bus multiplexer: consumes the selected 16-bit address (PC or register-bank address) plus the LDR/STR select.
- Runs one memory transaction per request against a variable-latency memory with a ready handshake.
- Returns fetched instructions and load data, acknowledges stores, and raises a stall while busy.
- Includes a wait-state timeout that reports a bus error.

Parameters:
ADDR_W, 16, address width (matches address bus)
DATA_W, 32, data word width
TIMEOUT, 15, max consecutive not-ready cycles before abort; 0 disables timeout

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  controller can accept request
sel_add_bus  input  1  1 = data access (LDR or STR), 0 = instruction fetch
write_en  input  1  1 = STR, 0 = LDR; ignored when sel_add_bus=0
address_add_bus_out  input  ADDR_W  selected address from address-bus mux
store_data  input  DATA_W  STR write data
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rd  output  1  memory read strobe
mem_wr  output  1  memory write strobe
mem_ready  input  1  memory completes access this cycle
mem_rdata  input  DATA_W  memory read data, valid when mem_ready=1
instr_out  output  DATA_W  last fetched instruction
instr_valid  output  1  one-cycle pulse, fetch complete
load_data  output  DATA_W  last loaded word
load_valid  output  1  one-cycle pulse, LDR complete
store_done  output  1  one-cycle pulse, STR complete
bus_error  output  1  one-cycle pulse, access aborted on timeout
stall  output  1  high whenever state != IDLE

Behaviour:
- States: IDLE, ACCESS, RESP. Reset forces IDLE.
- Reset values:
  - All registered outputs, mem_addr, mem_wdata, instr_out and load_data are 0.
  - Wait counter is 0.
  - req_ready is (state==IDLE) & ~reset, so it is 0 while reset is high.
- IDLE:
  - req_ready=1.
  - On req_valid=1, latch address, store_data, kind (FETCH if sel_add_bus=0, LOAD if sel_add_bus=1 and write_en=0, STORE if both 1), then go to ACCESS.
  - mem_ready is ignored.
- ACCESS, from the cycle after accept:
  - mem_addr holds the latched address.
  - mem_rd=1 for FETCH/LOAD; mem_wr=1 with mem_wdata=latched data for STORE.
  - mem_rd and mem_wr are never both high.
  - Strobes, address and data are held stable until exit; input changes after accept have no effect.
  - mem_ready=1 sampled: capture mem_rdata (FETCH→instr_out, LOAD→load_data), go to RESP.
  - mem_ready=0: increment the wait counter. When TIMEOUT!=0 and the counter reaches TIMEOUT, go to RESP flagged as error; the strobe is high for exactly TIMEOUT cycles.
- RESP, one cycle:
  - Strobes 0.
  - Pulse exactly one of instr_valid, load_valid, store_done, or bus_error.
  - Clear the wait counter, then go to IDLE.
- Latency: accept at cycle N, strobe from N+1. With ready at cycle M, the response pulse is at M+1 and the next accept is possible at M+2. Zero-wait throughput is one request per 3 cycles.
- instr_out and load_data hold their value until the next successful access of the same kind. Errors and stores never modify them.
- Timeout in exactly the TIMEOUT-th not-ready cycle wins only if mem_ready=0 that cycle; ready on the same cycle the counter would expire is a success.
- Reset mid-operation: strobes drop at the next edge, no response pulse, state returns to IDLE, outputs take their reset values.

Test Plan:
1. Fetch, zero wait: req sel_add_bus=0, addr 0x0010, mem_ready=1, mem_rdata=0xE3A01005 → mem_rd high only at N+1, instr_valid pulse at N+2 with instr_out=0xE3A01005, load_valid=0, req_ready high at N+3.
2. LDR, 3 wait states: addr 0x1234, ready on the 4th strobe cycle with rdata 0xDEADBEEF → mem_rd high 4 cycles, mem_addr=0x1234 throughout, load_valid pulse the next cycle with load_data=0xDEADBEEF, stall high and req_ready low from N+1 through the pulse cycle.
3. STR: addr 0x00FF, store_data 0x000000A5, 1 wait → mem_wr high 2 cycles, mem_wdata=0x000000A5, mem_rd=0, store_done pulse, load_data and instr_out unchanged.
4. Timeout: TIMEOUT=15, mem_ready held 0 → mem_rd high exactly 15 cycles, bus_error single pulse, no valid pulse, load_data unchanged, req_ready=1 next cycle; ready at the 15th cycle instead → load_valid, no bus_error.
5. Input change during access: after accepting addr 0x0040, drive address_add_bus_out=0xFFFF and store_data=0x12345678 → mem_addr stays 0x0040, mem_wdata unchanged.
6. Reset mid-access: assert reset during the 2nd wait cycle of an LDR → strobes 0 next cycle, no pulses, all outputs 0, req_ready=1 the first cycle after reset deasserts.
